// File: rtl/uart_message_sequencer.sv
// uart_message_sequencer: streams a compile-time byte string into a UART byte port.
// Optional continuous re-send with idle gap under UART_MESSAGE_SEQUENCER_REPEAT_EN.
module uart_message_sequencer #(
  parameter int                         MessageLength   = 3,
  parameter logic [8*MessageLength-1:0] Message         = "ABC",
  parameter int                         RepeatGapClocks = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       tx_byte_done,
  output logic [7:0] tx_byte,
  output logic       tx_byte_valid,
  output logic       busy,
  output logic       msg_done,
  output logic [7:0] byte_index
`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
  ,
  input  logic       repeat_en
`endif
);

  if (MessageLength < 1 || MessageLength > 256 ||
      RepeatGapClocks < 1 || RepeatGapClocks > 24'hFF_FFFF) begin : g_bad_param
    $error("uart_message_sequencer: illegal parameter");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
    ,
    S_GAP
`endif
  } state_t;

  localparam logic [7:0] LastIdx = 8'(MessageLength - 1);

  state_t     state_q;
  state_t     state_d;
  logic       abort_q;
  logic       abort_hit;
  logic       finish;
  logic [7:0] idx_n;

  assign abort_hit = abort_q | abort;
  assign finish    = abort_hit | (byte_index == LastIdx);
  assign idx_n     = (state_q == S_WAIT_DONE) ? byte_index + 8'd1 : 8'd0;

  // Byte 0 is the leftmost character: shift it to the top and take the MSB byte.
  function automatic logic [7:0] byte_at(input logic [7:0] i);
    logic [8*MessageLength-1:0] sh;
    sh = Message << {i, 3'b000};
    return sh[8*MessageLength-1 -: 8];
  endfunction

`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
  localparam logic [23:0] GapLoad = 24'(RepeatGapClocks - 1);

  logic [23:0] gap_q;
  logic        go_gap;

  assign go_gap = repeat_en & ~abort_hit;

  // Gap down-counter: loaded on entry, counts down while in Gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else if (state_d == S_GAP && state_q != S_GAP) begin
      gap_q <= GapLoad;
    end else if (state_q == S_GAP && gap_q != '0) begin
      gap_q <= gap_q - 24'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && tx_byte_done) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_byte_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_byte_done) begin
          if (!finish) state_d = S_ISSUE;
`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
          else if (go_gap) state_d = S_GAP;
`endif
          else state_d = S_IDLE;
        end
      end
`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
      S_GAP: begin
        if (abort || !repeat_en) state_d = S_IDLE;
        else if (gap_q == '0) state_d = S_ISSUE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    tx_byte_valid = (state_q == S_ISSUE);
    busy          = (state_q != S_IDLE);
  end

  // Byte/index load, done pulse and sticky abort flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_byte    <= 8'hFF;
      byte_index <= 8'd0;
      msg_done   <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      msg_done <= (state_q == S_WAIT_DONE) && tx_byte_done && finish;
      if (state_d == S_IDLE) begin
        abort_q <= 1'b0;
      end else if (abort && (state_q == S_ISSUE ||
                             state_q == S_WAIT_BUSY ||
                             state_q == S_WAIT_DONE)) begin
        abort_q <= 1'b1;
      end
      if (state_d == S_ISSUE) begin
        byte_index <= idx_n;
        tx_byte    <= byte_at(idx_n);
      end
    end
  end

endmodule

// File: tb/tb_uart_message_sequencer.sv
// tb_uart_message_sequencer: scoreboard bench with three sequencer instances
// ("ABC", "HELLO", single 8'h55) each driven by a model transmitter.
module tb_uart_message_sequencer;

  typedef struct {
    int         inst;
    logic [7:0] b;
    int         cyc;
    int         rise;
  } obs_t;

  typedef struct {
    int         inst;
    logic [7:0] b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start = '0;
  logic [2:0] abort = '0;
  logic [2:0] hold = '0;
  logic [2:0] done_in;
  logic [2:0] valid;
  logic [2:0] busy;
  logic [2:0] mdone;
  logic [7:0] txb [3];
  logic [7:0] idx [3];
`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
  logic [2:0] rep = '0;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise [3];
  int   md_cnt [3];
  int   md_cyc [3];
  logic prev_done [3];
  obs_t obs_q [$];
  exp_t exp_q [$];

  always #5 clk = ~clk;

  uart_message_sequencer
`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
    #(.RepeatGapClocks(10))
`endif
  u_abc (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .tx_byte_done(done_in[0]), .tx_byte(txb[0]), .tx_byte_valid(valid[0]),
    .busy(busy[0]), .msg_done(mdone[0]), .byte_index(idx[0])
`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
    , .repeat_en(rep[0])
`endif
  );

  uart_message_sequencer #(.MessageLength(5), .Message(40'("HELLO"))) u_hello (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .tx_byte_done(done_in[1]), .tx_byte(txb[1]), .tx_byte_valid(valid[1]),
    .busy(busy[1]), .msg_done(mdone[1]), .byte_index(idx[1])
`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
    , .repeat_en(rep[1])
`endif
  );

  uart_message_sequencer #(.MessageLength(1), .Message(8'h55)) u_one (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]),
    .tx_byte_done(done_in[2]), .tx_byte(txb[2]), .tx_byte_valid(valid[2]),
    .busy(busy[2]), .msg_done(mdone[2]), .byte_index(idx[2])
`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
    , .repeat_en(rep[2])
`endif
  );

  // Model transmitter: done drops the cycle after valid and stays low 20 cycles.
  for (genvar k = 0; k < 3; k++) begin : g_tx
    logic d;
    int   c;
    always @(posedge clk) begin
      if (rst) begin
        d <= 1'b1;
        c <= 0;
      end else if (valid[k]) begin
        d <= 1'b0;
        c <= 20;
      end else if (c != 0) begin
        c <= c - 1;
        if (c == 1) d <= 1'b1;
      end
    end
    assign done_in[k] = d & ~hold[k];
  end

  task automatic step();
    obs_t o;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (done_in[k] && !prev_done[k]) rise[k] = cyc;
      prev_done[k] = done_in[k];
      if (valid[k]) begin
        o.inst = k;
        o.b    = txb[k];
        o.cyc  = cyc;
        o.rise = rise[k];
        obs_q.push_back(o);
      end
      if (mdone[k]) begin
        md_cnt[k]++;
        md_cyc[k] = cyc;
      end
    end
  endtask

  task automatic push_exp(input int k, input logic [7:0] b);
    exp_t e;
    e.inst = k;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (txb[k] !== 8'hFF || valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
          mdone[k] !== 1'b0 || idx[k] !== 8'd0) begin
        errors++;
        $display("FAIL reset inst%0d: got byte=%h v=%b busy=%b md=%b idx=%0d, want FF 0 0 0 0",
                 k, txb[k], valid[k], busy[k], mdone[k], idx[k]);
      end
    end
    rst = 1'b0;
    step();
    obs_q.delete();
  endtask

  task automatic test_abc();
    exp_t e;
    obs_t o;
    int   m0, sc, n, want;
    m0 = md_cnt[0];
    push_exp(0, 8'h41);
    push_exp(0, 8'h42);
    push_exp(0, 8'h43);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    sc = cyc;
    for (int i = 0; i < 300 && md_cnt[0] == m0; i++) step();
    checks++;
    if (md_cnt[0] !== m0 + 1) begin
      errors++;
      $display("FAIL abc_msg_done: got %0d pulses, want 1", md_cnt[0] - m0);
    end
    checks++;
    if (busy[0] !== 1'b0 || md_cyc[0] !== rise[0] + 1) begin
      errors++;
      $display("FAIL abc_done_timing: got busy=%b md_cyc=%0d, want busy=0 md_cyc=%0d",
               busy[0], md_cyc[0], rise[0] + 1);
    end
    repeat (5) step();
    checks++;
    if (md_cnt[0] !== m0 + 1) begin
      errors++;
      $display("FAIL abc_done_width: got %0d pulses, want 1", md_cnt[0] - m0);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL abc_byte%0d: got none, want %h", n, e.b);
      end else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.b !== e.b) begin
          errors++;
          $display("FAIL abc_byte%0d: got inst%0d %h, want inst%0d %h", n, o.inst, o.b, e.inst, e.b);
        end
        want = (n == 0) ? sc : o.rise + 1;
        checks++;
        if (o.cyc !== want) begin
          errors++;
          $display("FAIL abc_latency%0d: got cycle %0d, want %0d", n, o.cyc, want);
        end
      end
      n++;
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL abc_extra: got %0d extra valids, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_single_byte();
    exp_t e;
    obs_t o;
    int   m0;
    logic idx_bad;
    m0 = md_cnt[2];
    idx_bad = 1'b0;
    push_exp(2, 8'h55);
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    for (int i = 0; i < 100 && md_cnt[2] == m0; i++) begin
      step();
      if (idx[2] !== 8'd0) idx_bad = 1'b1;
    end
    checks++;
    if (md_cnt[2] !== m0 + 1 || md_cyc[2] !== rise[2] + 1) begin
      errors++;
      $display("FAIL one_msg_done: got %0d pulses at %0d, want 1 at %0d",
               md_cnt[2] - m0, md_cyc[2], rise[2] + 1);
    end
    checks++;
    if (idx_bad !== 1'b0) begin
      errors++;
      $display("FAIL one_index: got nonzero byte_index, want 0");
    end
    repeat (5) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL one_byte: got none, want %h", e.b);
      end else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.b !== e.b) begin
          errors++;
          $display("FAIL one_byte: got inst%0d %h, want inst%0d %h", o.inst, o.b, e.inst, e.b);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL one_extra: got %0d extra valids, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_abort();
    exp_t e;
    obs_t o;
    int   m0;
    m0 = md_cnt[1];
    push_exp(1, 8'h48);
    push_exp(1, 8'h45);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    for (int i = 0; i < 200 && obs_q.size() < 2; i++) step();
    abort[1] = 1'b1;
    repeat (3) step();
    abort[1] = 1'b0;
    for (int i = 0; i < 200 && md_cnt[1] == m0; i++) step();
    checks++;
    if (md_cnt[1] !== m0 + 1 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: got %0d pulses busy=%b, want 1 busy=0", md_cnt[1] - m0, busy[1]);
    end
    repeat (60) step();
    checks++;
    if (md_cnt[1] !== m0 + 1 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got %0d pulses busy=%b, want 1 busy=0", md_cnt[1] - m0, busy[1]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL abort_byte: got none, want %h", e.b);
      end else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.b !== e.b) begin
          errors++;
          $display("FAIL abort_byte: got inst%0d %h, want inst%0d %h", o.inst, o.b, e.inst, e.b);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL abort_extra: got %0d extra valids (first %h), want 0",
               obs_q.size(), obs_q[0].b);
    end
    obs_q.delete();
  endtask

  task automatic test_tx_busy();
    exp_t e;
    obs_t o;
    int   m0;
    m0 = md_cnt[0];
    hold[0] = 1'b1;
    step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (5) step();
    checks++;
    if (obs_q.size() != 0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: got %0d valids busy=%b, want 0 busy=0", obs_q.size(), busy[0]);
    end
    obs_q.delete();
    hold[0] = 1'b0;
    repeat (3) step();
    push_exp(0, 8'h41);
    push_exp(0, 8'h42);
    push_exp(0, 8'h43);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int i = 0; i < 300 && md_cnt[0] == m0; i++) step();
    checks++;
    if (md_cnt[0] !== m0 + 1) begin
      errors++;
      $display("FAIL busy_second: got %0d pulses, want 1", md_cnt[0] - m0);
    end
    repeat (5) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL busy_byte: got none, want %h", e.b);
      end else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.b !== e.b) begin
          errors++;
          $display("FAIL busy_byte: got inst%0d %h, want inst%0d %h", o.inst, o.b, e.inst, e.b);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL busy_extra: got %0d extra valids, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    obs_t o;
    push_exp(1, 8'h48);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (txb[1] !== 8'hFF || valid[1] !== 1'b0 || busy[1] !== 1'b0 ||
        mdone[1] !== 1'b0 || idx[1] !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: got byte=%h v=%b busy=%b md=%b idx=%0d, want FF 0 0 0 0",
               txb[1], valid[1], busy[1], mdone[1], idx[1]);
    end
    repeat (60) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL reset_mid_byte: got none, want %h", e.b);
      end else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.b !== e.b) begin
          errors++;
          $display("FAIL reset_mid_byte: got inst%0d %h, want inst%0d %h", o.inst, o.b, e.inst, e.b);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_extra: got %0d valids after reset, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
  task automatic test_repeat();
    exp_t e;
    obs_t o;
    int   m0, m1;
    m0 = md_cnt[0];
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 8'h41);
      push_exp(0, 8'h42);
      push_exp(0, 8'h43);
    end
    rep[0] = 1'b1;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int i = 0; i < 300 && md_cnt[0] == m0; i++) step();
    m1 = md_cyc[0];
    for (int i = 0; i < 300 && obs_q.size() < 4; i++) step();
    checks++;
    if (obs_q.size() < 4 || obs_q[3].cyc !== m1 + 10) begin
      errors++;
      $display("FAIL repeat_gap: got restart at %0d, want %0d",
               (obs_q.size() < 4) ? -1 : obs_q[3].cyc, m1 + 10);
    end
    for (int i = 0; i < 300 && md_cnt[0] < m0 + 2; i++) step();
    step();
    rep[0] = 1'b0;
    repeat (2) step();
    checks++;
    if (busy[0] !== 1'b0 || md_cnt[0] !== m0 + 2) begin
      errors++;
      $display("FAIL repeat_drop: got busy=%b pulses=%0d, want busy=0 pulses=2",
               busy[0], md_cnt[0] - m0);
    end
    repeat (20) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL repeat_byte: got none, want %h", e.b);
      end else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.b !== e.b) begin
          errors++;
          $display("FAIL repeat_byte: got inst%0d %h, want inst%0d %h", o.inst, o.b, e.inst, e.b);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL repeat_extra: got %0d extra valids, want 0", obs_q.size());
    end
    obs_q.delete();
    m0 = md_cnt[0];
    rep[0] = 1'b1;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int i = 0; i < 300 && md_cnt[0] == m0; i++) step();
    step();
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    step();
    checks++;
    if (busy[0] !== 1'b0 || md_cnt[0] !== m0 + 1) begin
      errors++;
      $display("FAIL repeat_abort: got busy=%b pulses=%0d, want busy=0 pulses=1",
               busy[0], md_cnt[0] - m0);
    end
    rep[0] = 1'b0;
    repeat (20) step();
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL repeat_abort_bytes: got %0d valids, want 3", obs_q.size());
    end
    obs_q.delete();
  endtask
`endif

  initial begin
    for (int k = 0; k < 3; k++) begin
      rise[k]      = 0;
      md_cnt[k]    = 0;
      md_cyc[k]    = 0;
      prev_done[k] = 1'b0;
    end
    test_reset();
    test_abc();
    test_single_byte();
    test_abort();
    test_tx_busy();
    test_reset_mid();
`ifdef UART_MESSAGE_SEQUENCER_REPEAT_EN
    test_repeat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
